// File: rtl/id_ex_stage.sv
`timescale 1ns/1ps
// ID/EX pipeline register: latches the decoded instruction, scrubs don't-care
// control bits, resolves the write-back register and inserts load-use bubbles.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int RW = 5,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [10:0]   ctrl_in,
    input  logic          id_valid,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic          flush,
    input  logic          ex_hold,
    output logic          ex_valid,
    output logic [10:0]   ex_ctrl,
    output logic [RW-1:0] ex_rs,
    output logic [RW-1:0] ex_rt,
    output logic [RW-1:0] ex_dest,
    output logic [DW-1:0] ex_rs_data,
    output logic [DW-1:0] ex_rt_data,
    output logic [DW-1:0] ex_imm,
    output logic          stall,
    output logic [CW-1:0] stall_cycles
);

    logic          ex_valid_q, ex_valid_d;
    logic [10:0]   ex_ctrl_q, ex_ctrl_d;
    logic [RW-1:0] ex_rs_q, ex_rs_d;
    logic [RW-1:0] ex_rt_q, ex_rt_d;
    logic [RW-1:0] ex_dest_q, ex_dest_d;
    logic [DW-1:0] ex_rs_data_q, ex_rs_data_d;
    logic [DW-1:0] ex_rt_data_q, ex_rt_data_d;
    logic [DW-1:0] ex_imm_q, ex_imm_d;
    logic [CW-1:0] stall_cycles_q, stall_cycles_d;

    logic          jump, reg_write, reg_dst, mem_access, rt_used;
    logic [10:0]   ctrl_san;
    logic [RW-1:0] dest_san;
    logic          hazard;

    // Every sanitised bit is ANDed with a qualifier that is 0 whenever the raw
    // bit is a don't-care, so X never reaches EX for a decoded opcode.
    always_comb begin
        jump       = ctrl_in[1];
        reg_write  = ctrl_in[7];
        reg_dst    = ctrl_in[10] & reg_write & ~jump;
        mem_access = ctrl_in[6] | ctrl_in[5];
        ctrl_san     = '0;
        ctrl_san[10] = reg_dst;
        ctrl_san[9]  = ctrl_in[9] & ~reg_dst & ~jump;
        ctrl_san[8]  = ctrl_in[8] & reg_write & ~jump;
        ctrl_san[7]  = reg_write;
        ctrl_san[6]  = ctrl_in[6];
        ctrl_san[5]  = ctrl_in[5];
        ctrl_san[4]  = ctrl_in[4] & ~jump;
        ctrl_san[3]  = ctrl_in[3] & ~jump;
        ctrl_san[2]  = ctrl_in[2] & ~jump;
        ctrl_san[1]  = jump;
        ctrl_san[0]  = ctrl_in[0] & (ctrl_in[4] | mem_access) & ~jump;
        dest_san = '0;
        if (reg_write) begin
            dest_san = reg_dst ? id_rd : id_rt;
        end
    end

    // rt is a true source when the ALU takes it (no immediate) or a store writes it.
    always_comb begin
        rt_used = ~ctrl_san[9] | ctrl_san[5];
        hazard  = ex_valid_q & ex_ctrl_q[6] & (ex_rt_q != '0) & id_valid & ~jump &
                  ((ex_rt_q == id_rs) | ((ex_rt_q == id_rt) & rt_used));
        stall   = reset_n & (hazard | ex_hold) & ~flush;
    end

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_ctrl_d      = ex_ctrl_q;
        ex_rs_d        = ex_rs_q;
        ex_rt_d        = ex_rt_q;
        ex_dest_d      = ex_dest_q;
        ex_rs_data_d   = ex_rs_data_q;
        ex_rt_data_d   = ex_rt_data_q;
        ex_imm_d       = ex_imm_q;
        stall_cycles_d = stall_cycles_q;
        if (!ex_hold || flush) begin
            ex_rs_d      = id_rs;
            ex_rt_d      = id_rt;
            ex_rs_data_d = id_rs_data;
            ex_rt_data_d = id_rt_data;
            ex_imm_d     = id_imm;
            if (flush || hazard || !id_valid) begin
                ex_valid_d = 1'b0;
                ex_ctrl_d  = '0;
                ex_dest_d  = '0;
            end else begin
                ex_valid_d = 1'b1;
                ex_ctrl_d  = ctrl_san;
                ex_dest_d  = dest_san;
            end
        end
        if (hazard && !flush && !ex_hold && !(&stall_cycles_q)) begin
            stall_cycles_d = stall_cycles_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_valid_q     <= 1'b0;
            ex_ctrl_q      <= '0;
            ex_rs_q        <= '0;
            ex_rt_q        <= '0;
            ex_dest_q      <= '0;
            ex_rs_data_q   <= '0;
            ex_rt_data_q   <= '0;
            ex_imm_q       <= '0;
            stall_cycles_q <= '0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_ctrl_q      <= ex_ctrl_d;
            ex_rs_q        <= ex_rs_d;
            ex_rt_q        <= ex_rt_d;
            ex_dest_q      <= ex_dest_d;
            ex_rs_data_q   <= ex_rs_data_d;
            ex_rt_data_q   <= ex_rt_data_d;
            ex_imm_q       <= ex_imm_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_ctrl      = ex_ctrl_q;
    assign ex_rs        = ex_rs_q;
    assign ex_rt        = ex_rt_q;
    assign ex_dest      = ex_dest_q;
    assign ex_rs_data   = ex_rs_data_q;
    assign ex_rt_data   = ex_rt_data_q;
    assign ex_imm       = ex_imm_q;
    assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_id_ex_stage.sv
`timescale 1ns/1ps
// Bench for id_ex_stage: directed scenarios and a random instruction stream,
// with expected EX contents queued when stimulus is driven.
module tb_id_ex_stage;

    localparam int DW  = 32;
    localparam int RW  = 5;
    localparam int CW  = 16;
    localparam int SCW = 3;

    localparam logic [10:0] C_ADD      = 11'b10010001000;
    localparam logic [10:0] C_R_RAW    = 11'b1x01000100x;
    localparam logic [10:0] C_ADDI_RAW = 11'b01010000001;
    localparam logic [10:0] C_ADDI     = 11'b01010000000;
    localparam logic [10:0] C_LW       = 11'b01111000001;
    localparam logic [10:0] C_SW_RAW   = 11'bx1x00100001;
    localparam logic [10:0] C_SW       = 11'b01000100001;
    localparam logic [10:0] C_BEQ_RAW  = 11'bx0x00010101;
    localparam logic [10:0] C_BEQ      = 11'b00000010101;
    localparam logic [10:0] C_J_RAW    = 11'bxxx000xxx1x;
    localparam logic [10:0] C_J        = 11'b00000000010;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [10:0]   ctrl_in;
    logic          id_valid;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic          flush, ex_hold;
    logic          ex_valid, s_ex_valid;
    logic [10:0]   ex_ctrl, s_ex_ctrl;
    logic [RW-1:0] ex_rs, ex_rt, ex_dest, s_ex_rs, s_ex_rt, s_ex_dest;
    logic [DW-1:0] ex_rs_data, ex_rt_data, ex_imm;
    logic [DW-1:0] s_ex_rs_data, s_ex_rt_data, s_ex_imm;
    logic          stall, s_stall;
    logic [CW-1:0] stall_cycles;
    logic [SCW-1:0] s_stall_cycles;

    // [123] set means a bubble: only valid/ctrl/dest are compared.
    logic [123:0]  exp_q[$];
    logic [123:0]  exp_e, last_exp;
    logic [122:0]  obs_vec, s_obs_vec;
    int            total = 0;
    int            bad = 0;
    int            exp_cnt = 0;

    logic [10:0]   raw_tab[6];
    logic [10:0]   clean_tab[6];
    int            dsel_tab[6];
    logic          rtuse_tab[6];

    assign obs_vec   = {ex_valid, ex_ctrl, ex_dest, ex_rs, ex_rt, ex_rs_data, ex_rt_data, ex_imm};
    assign s_obs_vec = {s_ex_valid, s_ex_ctrl, s_ex_dest, s_ex_rs, s_ex_rt,
                        s_ex_rs_data, s_ex_rt_data, s_ex_imm};

    id_ex_stage #(.DW(DW), .RW(RW), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n), .ctrl_in(ctrl_in), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .flush(flush), .ex_hold(ex_hold),
        .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rs(ex_rs), .ex_rt(ex_rt),
        .ex_dest(ex_dest), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
        .ex_imm(ex_imm), .stall(stall), .stall_cycles(stall_cycles)
    );

    // Narrow-counter copy on the same inputs, so saturation is reachable quickly.
    id_ex_stage #(.DW(DW), .RW(RW), .CW(SCW)) dut_sat (
        .clk(clk), .reset_n(reset_n), .ctrl_in(ctrl_in), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .flush(flush), .ex_hold(ex_hold),
        .ex_valid(s_ex_valid), .ex_ctrl(s_ex_ctrl), .ex_rs(s_ex_rs), .ex_rt(s_ex_rt),
        .ex_dest(s_ex_dest), .ex_rs_data(s_ex_rs_data), .ex_rt_data(s_ex_rt_data),
        .ex_imm(s_ex_imm), .stall(s_stall), .stall_cycles(s_stall_cycles)
    );

    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [10:0] c, input logic v, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [4:0] rd);
        ctrl_in    = c;
        id_valid   = v;
        id_rs      = rs;
        id_rt      = rt;
        id_rd      = rd;
        id_rs_data = $urandom;
        id_rt_data = $urandom;
        id_imm     = $urandom;
    endtask

    function automatic logic [123:0] mk_full(input logic [10:0] c, input logic [4:0] d);
        return {1'b0, 1'b1, c, d, id_rs, id_rt, id_rs_data, id_rt_data, id_imm};
    endfunction

    function automatic logic [123:0] mk_bubble();
        return {1'b1, 123'd0};
    endfunction

    task automatic test_reset;
        drive(C_LW, 1'b1, 5'd1, 5'd2, 5'd3);
        flush   = 1'b0;
        ex_hold = 1'b1;
        repeat (2) tick;
        total++;
        if (obs_vec !== 123'd0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0", obs_vec);
        end
        total++;
        if (stall !== 1'b0 || stall_cycles !== 16'd0) begin
            bad++;
            $display("FAIL reset_stall: stall=%b cnt=%0d want 0/0", stall, stall_cycles);
        end
        ex_hold = 1'b0;
        drive(C_LW, 1'b0, 5'd0, 5'd0, 5'd0);
        reset_n = 1'b1;
        exp_q.delete();
        exp_cnt = 0;
    endtask

    task automatic test_sanitise;
        drive(C_R_RAW, 1'b1, 5'd1, 5'd3, 5'd5);
        exp_q.push_back(mk_full(C_ADD, 5'd5));
        tick;
        exp_e = exp_q.pop_front();
        total++;
        if (obs_vec !== exp_e[122:0]) begin
            bad++;
            $display("FAIL sanitise_rtype: got %h want %h", obs_vec, exp_e[122:0]);
        end
        total++;
        if ($isunknown({obs_vec, stall, stall_cycles})) begin
            bad++;
            $display("FAIL sanitise_no_x: got %h want no X", obs_vec);
        end
    endtask

    task automatic test_load_use;
        logic [123:0] add_e;
        drive(C_LW, 1'b1, 5'd2, 5'd8, 5'd0);
        exp_q.push_back(mk_full(C_LW, 5'd8));
        tick;
        exp_e = exp_q.pop_front();
        total++;
        if (obs_vec !== exp_e[122:0]) begin
            bad++;
            $display("FAIL lu_lw: got %h want %h", obs_vec, exp_e[122:0]);
        end
        drive(C_ADD, 1'b1, 5'd8, 5'd3, 5'd10);
        add_e = mk_full(C_ADD, 5'd10);
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL lu_stall: got %b want 1", stall);
        end
        exp_q.push_back(mk_bubble());
        exp_cnt++;
        tick;
        exp_e = exp_q.pop_front();
        total++;
        if (obs_vec[122:106] !== exp_e[122:106]) begin
            bad++;
            $display("FAIL lu_bubble: got %h want %h", obs_vec[122:106], exp_e[122:106]);
        end
        total++;
        if (stall !== 1'b0 || stall_cycles !== 16'(exp_cnt)) begin
            bad++;
            $display("FAIL lu_one_cycle: stall=%b cnt=%0d want 0/%0d", stall, stall_cycles, exp_cnt);
        end
        exp_q.push_back(add_e);
        tick;
        exp_e = exp_q.pop_front();
        total++;
        if (obs_vec !== exp_e[122:0]) begin
            bad++;
            $display("FAIL lu_add: got %h want %h", obs_vec, exp_e[122:0]);
        end
    endtask

    task automatic test_no_hazard;
        drive(C_LW, 1'b1, 5'd1, 5'd8, 5'd0);
        tick;
        drive(C_ADDI_RAW, 1'b1, 5'd4, 5'd8, 5'd0);
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL nh_addi_stall: got %b want 0", stall);
        end
        exp_q.push_back(mk_full(C_ADDI, 5'd8));
        tick;
        exp_e = exp_q.pop_front();
        total++;
        if (obs_vec !== exp_e[122:0]) begin
            bad++;
            $display("FAIL nh_addi: got %h want %h", obs_vec, exp_e[122:0]);
        end
        drive(C_LW, 1'b1, 5'd1, 5'd0, 5'd0);
        tick;
        drive(C_ADD, 1'b1, 5'd0, 5'd6, 5'd7);
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL nh_zero_stall: got %b want 0", stall);
        end
        exp_q.push_back(mk_full(C_ADD, 5'd7));
        tick;
        exp_e = exp_q.pop_front();
        total++;
        if (obs_vec !== exp_e[122:0]) begin
            bad++;
            $display("FAIL nh_zero_add: got %h want %h", obs_vec, exp_e[122:0]);
        end
    endtask

    task automatic test_sw_dep;
        logic [123:0] sw_e;
        drive(C_LW, 1'b1, 5'd1, 5'd9, 5'd0);
        tick;
        drive(C_SW_RAW, 1'b1, 5'd1, 5'd9, 5'd12);
        sw_e = mk_full(C_SW, 5'd0);
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL sw_stall: got %b want 1", stall);
        end
        exp_q.push_back(mk_bubble());
        exp_q.push_back(sw_e);
        exp_cnt++;
        for (int k = 0; k < 2; k++) begin
            tick;
            exp_e = exp_q.pop_front();
            total++;
            if (exp_e[123] ? (obs_vec[122:106] !== exp_e[122:106]) : (obs_vec !== exp_e[122:0])) begin
                bad++;
                $display("FAIL sw_seq%0d: got %h want %h", k, obs_vec, exp_e[122:0]);
            end
        end
        total++;
        if (stall_cycles !== 16'(exp_cnt)) begin
            bad++;
            $display("FAIL sw_count: got %0d want %0d", stall_cycles, exp_cnt);
        end
    endtask

    task automatic test_flush;
        drive(C_LW, 1'b1, 5'd1, 5'd8, 5'd0);
        tick;
        drive(C_ADD, 1'b1, 5'd8, 5'd2, 5'd11);
        flush = 1'b1;
        #1;
        total++;
        if (stall !== 1'b0) begin
            bad++;
            $display("FAIL flush_stall: got %b want 0", stall);
        end
        exp_q.push_back(mk_bubble());
        tick;
        flush = 1'b0;
        exp_e = exp_q.pop_front();
        total++;
        if (obs_vec[122:106] !== exp_e[122:106] || stall_cycles !== 16'(exp_cnt)) begin
            bad++;
            $display("FAIL flush_bubble: got %h cnt=%0d want %h cnt=%0d",
                     obs_vec[122:106], stall_cycles, exp_e[122:106], exp_cnt);
        end
        drive(C_J_RAW, 1'b1, 5'd8, 5'd8, 5'd4);
        exp_q.push_back(mk_full(C_J, 5'd0));
        tick;
        exp_e = exp_q.pop_front();
        total++;
        if (obs_vec !== exp_e[122:0]) begin
            bad++;
            $display("FAIL jump_sanitise: got %h want %h", obs_vec, exp_e[122:0]);
        end
    endtask

    task automatic test_hold;
        drive(C_ADD, 1'b1, 5'd1, 5'd2, 5'd3);
        last_exp = mk_full(C_ADD, 5'd3);
        tick;
        ex_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(C_LW, 1'b1, 5'(k + 4), 5'(k + 5), 5'd0);
            #1;
            total++;
            if (stall !== 1'b1) begin
                bad++;
                $display("FAIL hold_stall%0d: got %b want 1", k, stall);
            end
            exp_q.push_back(last_exp);
            tick;
            exp_e = exp_q.pop_front();
            total++;
            if (obs_vec !== exp_e[122:0] || stall_cycles !== 16'(exp_cnt)) begin
                bad++;
                $display("FAIL hold_frozen%0d: got %h want %h", k, obs_vec, exp_e[122:0]);
            end
        end
        ex_hold = 1'b0;
        drive(C_LW, 1'b1, 5'd1, 5'd5, 5'd0);
        last_exp = mk_full(C_LW, 5'd5);
        tick;
        drive(C_ADD, 1'b1, 5'd5, 5'd1, 5'd14);
        ex_hold = 1'b1;
        for (int k = 0; k < 2; k++) begin
            exp_q.push_back(last_exp);
            tick;
            exp_e = exp_q.pop_front();
            total++;
            if (obs_vec !== exp_e[122:0] || stall_cycles !== 16'(exp_cnt)) begin
                bad++;
                $display("FAIL hold_haz%0d: got %h cnt=%0d want %h cnt=%0d",
                         k, obs_vec, stall_cycles, exp_e[122:0], exp_cnt);
            end
        end
        ex_hold = 1'b0;
        exp_q.push_back(mk_bubble());
        exp_q.push_back(mk_full(C_ADD, 5'd14));
        exp_cnt++;
        for (int k = 0; k < 2; k++) begin
            tick;
            exp_e = exp_q.pop_front();
            total++;
            if (exp_e[123] ? (obs_vec[122:106] !== exp_e[122:106]) : (obs_vec !== exp_e[122:0])) begin
                bad++;
                $display("FAIL hold_release%0d: got %h want %h", k, obs_vec, exp_e[122:0]);
            end
        end
    endtask

    task automatic test_back_to_back;
        int op;
        logic prev_stall, haz, exp_s, m_valid, m_mr;
        logic [4:0] m_rt;
        drive(C_ADD, 1'b0, 5'd0, 5'd0, 5'd0);
        tick;
        m_valid = 1'b0;
        m_mr = 1'b0;
        m_rt = '0;
        last_exp = mk_bubble();
        prev_stall = 1'b0;
        op = 0;
        for (int n = 0; n < 120; n++) begin
            if (!prev_stall) begin
                op = $urandom_range(0, 6);
                drive(op == 6 ? C_ADD : raw_tab[op], op != 6, 5'($urandom_range(0, 3)),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 31)));
            end
            flush   = ($urandom_range(0, 9) == 0);
            ex_hold = ($urandom_range(0, 7) == 0);
            haz = 1'b0;
            if (op != 6 && op != 5 && m_valid && m_mr && m_rt != 0)
                haz = (m_rt == id_rs) || (m_rt == id_rt && rtuse_tab[op]);
            exp_s = (haz || ex_hold) && !flush;
            #1;
            total++;
            if (stall !== exp_s || s_stall !== exp_s) begin
                bad++;
                $display("FAIL rnd_stall%0d: got %b/%b want %b", n, stall, s_stall, exp_s);
            end
            if (flush) begin
                exp_e = mk_bubble();
                m_valid = 1'b0;
            end else if (ex_hold) begin
                exp_e = last_exp;
            end else if (haz) begin
                exp_e = mk_bubble();
                m_valid = 1'b0;
                exp_cnt++;
            end else if (op != 6) begin
                exp_e = mk_full(clean_tab[op], dsel_tab[op] == 2 ? id_rd :
                                dsel_tab[op] == 1 ? id_rt : 5'd0);
                m_valid = 1'b1;
                m_mr = (op == 2);
                m_rt = id_rt;
            end else begin
                exp_e = mk_bubble();
                m_valid = 1'b0;
            end
            exp_q.push_back(exp_e);
            last_exp = exp_e;
            prev_stall = exp_s;
            tick;
            exp_e = exp_q.pop_front();
            total++;
            if (exp_e[123] ? (obs_vec[122:106] !== exp_e[122:106] || s_obs_vec[122:106] !== exp_e[122:106])
                           : (obs_vec !== exp_e[122:0] || s_obs_vec !== exp_e[122:0])) begin
                bad++;
                $display("FAIL rnd_ex%0d: got %h want %h", n, obs_vec, exp_e[122:0]);
            end
        end
        flush = 1'b0;
        ex_hold = 1'b0;
        total++;
        if (stall_cycles !== 16'(exp_cnt)) begin
            bad++;
            $display("FAIL rnd_count: got %0d want %0d", stall_cycles, exp_cnt);
        end
    endtask

    task automatic test_saturation;
        drive(C_ADD, 1'b0, 5'd0, 5'd0, 5'd0);
        tick;
        for (int k = 0; k < 8; k++) begin
            drive(C_LW, 1'b1, 5'd1, 5'd7, 5'd0);
            tick;
            drive(C_ADD, 1'b1, 5'd7, 5'd2, 5'd3);
            exp_cnt++;
            repeat (2) tick;
            total++;
            if (stall_cycles !== 16'(exp_cnt) ||
                s_stall_cycles !== SCW'(exp_cnt > 7 ? 7 : exp_cnt)) begin
                bad++;
                $display("FAIL sat_count%0d: got %0d/%0d want %0d/%0d", k, stall_cycles,
                         s_stall_cycles, exp_cnt, exp_cnt > 7 ? 7 : exp_cnt);
            end
        end
        total++;
        if (s_stall_cycles !== 3'b111) begin
            bad++;
            $display("FAIL sat_allones: got %0d want 7", s_stall_cycles);
        end
    endtask

    task automatic test_reset_mid_stall;
        drive(C_LW, 1'b1, 5'd1, 5'd6, 5'd0);
        tick;
        drive(C_ADD, 1'b1, 5'd6, 5'd2, 5'd3);
        #1;
        total++;
        if (stall !== 1'b1) begin
            bad++;
            $display("FAIL mid_setup_stall: got %b want 1", stall);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if (obs_vec !== 123'd0 || stall !== 1'b0 || stall_cycles !== 16'd0 || s_stall_cycles !== 3'd0) begin
            bad++;
            $display("FAIL mid_reset: got %h stall=%b cnt=%0d want 0", obs_vec, stall, stall_cycles);
        end
        tick;
        reset_n = 1'b1;
        exp_q.delete();
        exp_cnt = 0;
    endtask

    initial begin
        raw_tab   = '{C_R_RAW, C_ADDI_RAW, C_LW, C_SW_RAW, C_BEQ_RAW, C_J_RAW};
        clean_tab = '{C_ADD, C_ADDI, C_LW, C_SW, C_BEQ, C_J};
        dsel_tab  = '{2, 1, 1, 0, 0, 0};
        rtuse_tab = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        flush = 1'b0;
        ex_hold = 1'b0;
        drive(C_ADD, 1'b0, 5'd0, 5'd0, 5'd0);
        test_reset;
        test_sanitise;
        test_load_use;
        test_no_hazard;
        test_sw_dep;
        test_flush;
        test_hold;
        test_back_to_back;
        test_saturation;
        test_reset_mid_stall;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
